// File: rtl/sv39_tlb_pkg.sv
// Shared encodings for the Sv39 TLB: sfence.vma invalidate modes, PTE flag bit positions and page levels.
package sv39_tlb_pkg;

  localparam logic [1:0] TLB_INV_ALL     = 2'b00;
  localparam logic [1:0] TLB_INV_VA      = 2'b01;
  localparam logic [1:0] TLB_INV_ASID    = 2'b10;
  localparam logic [1:0] TLB_INV_VA_ASID = 2'b11;

  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  localparam int PTE_X = 3;
  localparam int PTE_U = 4;
  localparam int PTE_G = 5;
  localparam int PTE_A = 6;
  localparam int PTE_D = 7;

  localparam logic [1:0] LVL_4K = 2'd0;
  localparam logic [1:0] LVL_2M = 2'd1;
  localparam logic [1:0] LVL_1G = 2'd2;
  localparam logic [1:0] LVL_BAD = 2'd3;

endpackage

// File: rtl/sv39_tlb_entry_match.sv
// Combinational per-entry comparator. VPN is compared only on the levels the entry's page size covers;
// g_wild_i selects whether a global entry matches any ASID (lookup/fill) or is excluded (ASID sfence).
module tlb_entry_match
  import sv39_tlb_pkg::*;
#(
  parameter int VPN_BITS  = 27,
  parameter int ASID_BITS = 16
) (
  input  logic                 valid_i,
  input  logic [VPN_BITS-1:0]  e_vpn_i,
  input  logic [ASID_BITS-1:0] e_asid_i,
  input  logic [1:0]           e_level_i,
  input  logic                 e_g_i,
  input  logic [VPN_BITS-1:0]  q_vpn_i,
  input  logic [ASID_BITS-1:0] q_asid_i,
  input  logic                 chk_vpn_i,
  input  logic                 chk_asid_i,
  input  logic                 g_wild_i,
  output logic                 match_o
);

  logic [VPN_BITS-1:0] mask;
  logic                vpn_ok;
  logic                asid_eq;
  logic                asid_ok;

  always_comb begin
    mask = {VPN_BITS{1'b1}};
    case (e_level_i)
      LVL_2M:  mask = {VPN_BITS{1'b1}} << 9;
      LVL_1G:  mask = {VPN_BITS{1'b1}} << 18;
      default: mask = {VPN_BITS{1'b1}};
    endcase
  end

  assign vpn_ok  = !chk_vpn_i || (((e_vpn_i ^ q_vpn_i) & mask) == '0);
  assign asid_eq = (e_asid_i == q_asid_i);
  assign asid_ok = !chk_asid_i || (g_wild_i ? (e_g_i || asid_eq) : (!e_g_i && asid_eq));
  assign match_o = valid_i && vpn_ok && asid_ok;

endmodule

// File: rtl/sv39_tlb.sv
// Fully associative Sv39 fetch TLB: 1-cycle registered lookup, walker fill with
// same-page/invalid/round-robin victim choice, and sfence.vma invalidate applied ahead of a same-cycle fill.
module sv39_tlb
  import sv39_tlb_pkg::*;
#(
  parameter int NUM_ENTRIES = 8,
  parameter int VPN_BITS    = 27,
  parameter int PPN_BITS    = 44,
  parameter int ASID_BITS   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lookup_valid,
  input  logic [VPN_BITS-1:0]  lookup_vpn,
  input  logic [ASID_BITS-1:0] lookup_asid,
  output logic                 resp_valid,
  output logic                 resp_hit,
  output logic [PPN_BITS-1:0]  resp_ppn,
  output logic [7:0]           resp_flags,
  output logic [1:0]           resp_level,
  input  logic                 fill_valid,
  input  logic [VPN_BITS-1:0]  fill_vpn,
  input  logic [ASID_BITS-1:0] fill_asid,
  input  logic [PPN_BITS-1:0]  fill_ppn,
  input  logic [7:0]           fill_flags,
  input  logic [1:0]           fill_level,
  input  logic                 tlb_invalidate,
  input  logic [1:0]           tlb_invalidate_mode,
  input  logic [VPN_BITS-1:0]  inv_vpn,
  input  logic [ASID_BITS-1:0] inv_asid
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]                valid_q, valid_d, valid_post;
  logic [NUM_ENTRIES-1:0][VPN_BITS-1:0]  vpn_q;
  logic [NUM_ENTRIES-1:0][ASID_BITS-1:0] asid_q;
  logic [NUM_ENTRIES-1:0][PPN_BITS-1:0]  ppn_q;
  logic [NUM_ENTRIES-1:0][7:0]           flags_q;
  logic [NUM_ENTRIES-1:0][1:0]           level_q;
  logic [IDX_W-1:0]                      rr_q, rr_d;

  logic [NUM_ENTRIES-1:0] lk_hit, inv_hit, fill_hit;

  logic                resp_valid_q, resp_hit_q;
  logic [PPN_BITS-1:0] resp_ppn_q;
  logic [7:0]          resp_flags_q;
  logic [1:0]          resp_level_q;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cmp
    tlb_entry_match #(.VPN_BITS(VPN_BITS), .ASID_BITS(ASID_BITS)) u_lk (
      .valid_i(valid_q[i]), .e_vpn_i(vpn_q[i]), .e_asid_i(asid_q[i]), .e_level_i(level_q[i]),
      .e_g_i(flags_q[i][PTE_G]), .q_vpn_i(lookup_vpn), .q_asid_i(lookup_asid),
      .chk_vpn_i(1'b1), .chk_asid_i(1'b1), .g_wild_i(1'b1), .match_o(lk_hit[i])
    );
    // Mode bit 0 selects the VPN compare, bit 1 the ASID compare; mode 00 therefore matches every valid entry.
    tlb_entry_match #(.VPN_BITS(VPN_BITS), .ASID_BITS(ASID_BITS)) u_inv (
      .valid_i(valid_q[i]), .e_vpn_i(vpn_q[i]), .e_asid_i(asid_q[i]), .e_level_i(level_q[i]),
      .e_g_i(flags_q[i][PTE_G]), .q_vpn_i(inv_vpn), .q_asid_i(inv_asid),
      .chk_vpn_i(tlb_invalidate_mode[0]), .chk_asid_i(tlb_invalidate_mode[1]), .g_wild_i(1'b0),
      .match_o(inv_hit[i])
    );
    tlb_entry_match #(.VPN_BITS(VPN_BITS), .ASID_BITS(ASID_BITS)) u_fill (
      .valid_i(valid_post[i] && (level_q[i] == fill_level)), .e_vpn_i(vpn_q[i]), .e_asid_i(asid_q[i]),
      .e_level_i(level_q[i]), .e_g_i(flags_q[i][PTE_G]), .q_vpn_i(fill_vpn), .q_asid_i(fill_asid),
      .chk_vpn_i(1'b1), .chk_asid_i(1'b1), .g_wild_i(1'b1), .match_o(fill_hit[i])
    );
  end

  assign valid_post = tlb_invalidate ? (valid_q & ~inv_hit) : valid_q;

  logic             lk_any, same_any, free_any, fill_do;
  logic [IDX_W-1:0] lk_idx, same_idx, free_idx, victim;

  always_comb begin
    lk_any   = 1'b0;
    lk_idx   = '0;
    same_any = 1'b0;
    same_idx = '0;
    free_any = 1'b0;
    free_idx = '0;
    // Scanning downward leaves the lowest matching index in each encoder.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lk_hit[i]) begin
        lk_any = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (fill_hit[i]) begin
        same_any = 1'b1;
        same_idx = IDX_W'(i);
      end
      if (!valid_post[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    fill_do = fill_valid && (fill_level != LVL_BAD);
    victim  = rr_q;
    rr_d    = rr_q;
    if (same_any) begin
      victim = same_idx;
    end else if (free_any) begin
      victim = free_idx;
    end else if (fill_do) begin
      rr_d = rr_q + 1'b1;
    end
    valid_d = valid_post;
    if (fill_do) valid_d[victim] = 1'b1;
  end

  logic [PPN_BITS-1:0] lk_ppn;

  always_comb begin
    lk_ppn = ppn_q[lk_idx];
    case (level_q[lk_idx])
      LVL_2M:  lk_ppn = {ppn_q[lk_idx][PPN_BITS-1:9], lookup_vpn[8:0]};
      LVL_1G:  lk_ppn = {ppn_q[lk_idx][PPN_BITS-1:18], lookup_vpn[17:0]};
      default: lk_ppn = ppn_q[lk_idx];
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q      <= '0;
      vpn_q        <= '0;
      asid_q       <= '0;
      ppn_q        <= '0;
      flags_q      <= '0;
      level_q      <= '0;
      rr_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_ppn_q   <= '0;
      resp_flags_q <= '0;
      resp_level_q <= '0;
    end else begin
      valid_q <= valid_d;
      rr_q    <= rr_d;
      if (fill_do) begin
        vpn_q[victim]   <= fill_vpn;
        asid_q[victim]  <= fill_asid;
        ppn_q[victim]   <= fill_ppn;
        flags_q[victim] <= fill_flags;
        level_q[victim] <= fill_level;
      end
      resp_valid_q <= lookup_valid;
      resp_hit_q   <= lookup_valid && lk_any;
      resp_ppn_q   <= (lookup_valid && lk_any) ? lk_ppn : '0;
      resp_flags_q <= (lookup_valid && lk_any) ? flags_q[lk_idx] : '0;
      resp_level_q <= (lookup_valid && lk_any) ? level_q[lk_idx] : '0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_ppn   = resp_ppn_q;
  assign resp_flags = resp_flags_q;
  assign resp_level = resp_level_q;

endmodule

// File: tb/tb_sv39_tlb.sv
// Directed bench for sv39_tlb: reset, 4K/superpage hits, replacement, sfence modes and same-cycle ordering.
module tb_sv39_tlb;

  logic        clock = 1'b0;
  logic        reset;
  logic        lookup_valid;
  logic [26:0] lookup_vpn;
  logic [15:0] lookup_asid;
  logic        resp_valid, resp_hit;
  logic [43:0] resp_ppn;
  logic [7:0]  resp_flags;
  logic [1:0]  resp_level;
  logic        fill_valid;
  logic [26:0] fill_vpn;
  logic [15:0] fill_asid;
  logic [43:0] fill_ppn;
  logic [7:0]  fill_flags;
  logic [1:0]  fill_level;
  logic        tlb_invalidate;
  logic [1:0]  tlb_invalidate_mode;
  logic [26:0] inv_vpn;
  logic [15:0] inv_asid;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  sv39_tlb dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn), .lookup_asid(lookup_asid),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_ppn(resp_ppn),
    .resp_flags(resp_flags), .resp_level(resp_level),
    .fill_valid(fill_valid), .fill_vpn(fill_vpn), .fill_asid(fill_asid), .fill_ppn(fill_ppn),
    .fill_flags(fill_flags), .fill_level(fill_level),
    .tlb_invalidate(tlb_invalidate), .tlb_invalidate_mode(tlb_invalidate_mode),
    .inv_vpn(inv_vpn), .inv_asid(inv_asid)
  );

  task automatic step();
    @(posedge clock);
    #1;
    lookup_valid   = 1'b0;
    fill_valid     = 1'b0;
    tlb_invalidate = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_fill(input logic [26:0] v, input logic [15:0] a, input logic [43:0] p,
                          input logic [7:0] f, input logic [1:0] l);
    fill_valid = 1'b1; fill_vpn = v; fill_asid = a; fill_ppn = p; fill_flags = f; fill_level = l;
  endtask

  task automatic set_lookup(input logic [26:0] v, input logic [15:0] a);
    lookup_valid = 1'b1; lookup_vpn = v; lookup_asid = a;
  endtask

  task automatic set_inv(input logic [1:0] m, input logic [26:0] v, input logic [15:0] a);
    tlb_invalidate = 1'b1; tlb_invalidate_mode = m; inv_vpn = v; inv_asid = a;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({resp_valid, resp_hit, resp_ppn, resp_flags, resp_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b h=%0b ppn=%h f=%h l=%0d, want all 0",
               resp_valid, resp_hit, resp_ppn, resp_flags, resp_level);
    end
    set_lookup(27'h0000123, 16'd0); step();
    n_chk++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_ppn !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_lookup: got v=%0b h=%0b ppn=%h, want v=1 h=0 ppn=0", resp_valid, resp_hit, resp_ppn);
    end
  endtask

  task automatic test_fill_4k();
    set_fill(27'h0000123, 16'd5, 44'hABCDE, 8'hCF, 2'd0); step();
    set_lookup(27'h0000123, 16'd5); step();
    n_chk++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b1 || resp_ppn !== 44'hABCDE || resp_flags !== 8'hCF || resp_level !== 2'd0) begin
      n_fail++;
      $display("FAIL fill4k_hit: got v=%0b h=%0b ppn=%h f=%h l=%0d, want 1 1 abcde cf 0",
               resp_valid, resp_hit, resp_ppn, resp_flags, resp_level);
    end
    set_lookup(27'h0000123, 16'd6); step();
    n_chk++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0 || resp_ppn !== 44'h0 || resp_flags !== 8'h0) begin
      n_fail++;
      $display("FAIL fill4k_asid_miss: got v=%0b h=%0b ppn=%h f=%h, want 1 0 0 0", resp_valid, resp_hit, resp_ppn, resp_flags);
    end
  endtask

  task automatic test_superpage();
    set_fill(27'h0040200, 16'd5, 44'h80200, 8'h0F, 2'd1); step();
    set_lookup(27'h00402AB, 16'd5); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h802AB || resp_level !== 2'd1) begin
      n_fail++;
      $display("FAIL super_2m: got h=%0b ppn=%h l=%0d, want 1 802ab 1", resp_hit, resp_ppn, resp_level);
    end
    set_fill(27'h04C0000, 16'd5, 44'h3000000, 8'h0F, 2'd2); step();
    set_lookup(27'h04C1234, 16'd5); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h3001234 || resp_level !== 2'd2) begin
      n_fail++;
      $display("FAIL super_1g: got h=%0b ppn=%h l=%0d, want 1 3001234 2", resp_hit, resp_ppn, resp_level);
    end
    set_fill(27'h0000555, 16'd5, 44'h111, 8'h0F, 2'd3); step();
    set_lookup(27'h0000555, 16'd5); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL level3_ignored: got h=%0b, want 0", resp_hit);
    end
  endtask

  task automatic test_replacement();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_fill(27'h100 + 27'(i), 16'd1, 44'h200 + 44'(i), 8'h0F, 2'd0); step();
    end
    set_lookup(27'h100, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_first_evicted: got h=%0b, want 0", resp_hit);
    end
    set_lookup(27'h108, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h208) begin
      n_fail++;
      $display("FAIL rr_ninth_hit: got h=%0b ppn=%h, want 1 208", resp_hit, resp_ppn);
    end
    // Pointer is now 1: the next eviction must take the second VPN and leave the third.
    set_fill(27'h109, 16'd1, 44'h209, 8'h0F, 2'd0); step();
    set_lookup(27'h101, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_ptr_one: got h=%0b for vpn 101, want 0", resp_hit);
    end
    set_lookup(27'h102, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h202) begin
      n_fail++;
      $display("FAIL rr_third_kept: got h=%0b ppn=%h, want 1 202", resp_hit, resp_ppn);
    end
  endtask

  task automatic test_refill_same();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_fill(27'h300 + 27'(i), 16'd2, 44'h400 + 44'(i), 8'h0F, 2'd0); step();
    end
    set_fill(27'h302, 16'd2, 44'h999, 8'h0F, 2'd0); step();
    set_lookup(27'h302, 16'd2); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h999) begin
      n_fail++;
      $display("FAIL refill_overwrite: got h=%0b ppn=%h, want 1 999", resp_hit, resp_ppn);
    end
    set_fill(27'h3FF, 16'd2, 44'h4FF, 8'h0F, 2'd0); step();
    set_lookup(27'h300, 16'd2); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_no_rr_advance: vpn 300 got h=%0b, want 0", resp_hit);
    end
    set_lookup(27'h301, 16'd2); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h401) begin
      n_fail++;
      $display("FAIL refill_second_kept: got h=%0b ppn=%h, want 1 401", resp_hit, resp_ppn);
    end
  endtask

  task automatic test_invalidate();
    do_reset();
    set_fill(27'h50, 16'd3, 44'h550, 8'h0F, 2'd0); step();
    set_fill(27'h60, 16'd7, 44'h660, 8'h2F, 2'd0); step();
    set_inv(2'b10, 27'h0, 16'd3); step();
    set_lookup(27'h50, 16'd3); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_asid_kill: got h=%0b, want 0", resp_hit);
    end
    set_lookup(27'h60, 16'd3); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h660 || resp_flags !== 8'h2F) begin
      n_fail++;
      $display("FAIL inv_asid_global_kept: got h=%0b ppn=%h f=%h, want 1 660 2f", resp_hit, resp_ppn, resp_flags);
    end
    set_inv(2'b00, 27'h0, 16'd0); step();
    set_lookup(27'h60, 16'd7); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_all: got h=%0b, want 0", resp_hit);
    end
    set_fill(27'h70, 16'd9, 44'h770, 8'h2F, 2'd0); step();
    set_fill(27'h80, 16'd4, 44'h880, 8'h0F, 2'd0); step();
    set_inv(2'b11, 27'h70, 16'd9); step();
    set_inv(2'b11, 27'h80, 16'd4); step();
    set_lookup(27'h70, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h770) begin
      n_fail++;
      $display("FAIL inv_va_asid_global_kept: got h=%0b ppn=%h, want 1 770", resp_hit, resp_ppn);
    end
    set_lookup(27'h80, 16'd4); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_va_asid_kill: got h=%0b, want 0", resp_hit);
    end
    set_inv(2'b01, 27'h70, 16'd0); step();
    set_lookup(27'h70, 16'd9); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_va_global_kill: got h=%0b, want 0", resp_hit);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_fill(27'h10, 16'd1, 44'h1010, 8'h0F, 2'd0); step();
    set_inv(2'b00, 27'h0, 16'd0);
    set_fill(27'h7, 16'd1, 44'h777, 8'h0F, 2'd0);
    set_lookup(27'h10, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h1010) begin
      n_fail++;
      $display("FAIL same_cycle_pre_edge: got h=%0b ppn=%h, want 1 1010", resp_hit, resp_ppn);
    end
    set_lookup(27'h7, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b1 || resp_ppn !== 44'h777) begin
      n_fail++;
      $display("FAIL fill_survives_inv: got h=%0b ppn=%h, want 1 777", resp_hit, resp_ppn);
    end
    set_lookup(27'h10, 16'd1); step();
    n_chk++;
    if (resp_valid !== 1'b1 || resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_all_old_gone: got v=%0b h=%0b, want 1 0", resp_valid, resp_hit);
    end
    step();
    n_chk++;
    if (resp_valid !== 1'b0 || resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_resp: got v=%0b h=%0b, want 0 0", resp_valid, resp_hit);
    end
  endtask

  task automatic test_reset_mid();
    set_lookup(27'h7, 16'd1); step();
    reset = 1'b1;
    set_fill(27'h44, 16'd1, 44'h444, 8'h0F, 2'd0);
    set_lookup(27'h7, 16'd1); step();
    reset = 1'b0;
    n_chk++;
    if ({resp_valid, resp_hit, resp_ppn, resp_flags, resp_level} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%0b h=%0b ppn=%h f=%h l=%0d, want all 0",
               resp_valid, resp_hit, resp_ppn, resp_flags, resp_level);
    end
    set_lookup(27'h44, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fill_dropped: got h=%0b, want 0", resp_hit);
    end
    set_lookup(27'h7, 16'd1); step();
    n_chk++;
    if (resp_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_entries_cleared: got h=%0b, want 0", resp_hit);
    end
  endtask

  initial begin
    reset = 1'b1;
    lookup_valid = 1'b0; lookup_vpn = '0; lookup_asid = '0;
    fill_valid = 1'b0; fill_vpn = '0; fill_asid = '0; fill_ppn = '0; fill_flags = '0; fill_level = '0;
    tlb_invalidate = 1'b0; tlb_invalidate_mode = '0; inv_vpn = '0; inv_asid = '0;
    test_reset();
    test_fill_4k();
    test_superpage();
    test_replacement();
    test_refill_same();
    test_invalidate();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
